// File: rtl/branch_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// branch_hazard_ctrl_pkg
// Shared types and constants for the ID-stage branch sequencing logic.
//   regName_t      - architectural register index (x0..x31)
//   REG_ZERO       - hard-wired zero register; never a real producer
//   brCtrlState_t  - branch controller state encoding
//   BR_STALL_LD_*  - default stall lengths for load producers in EX / MEM
// ---------------------------------------------------------------------------
package branch_hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] regName_t;

  localparam regName_t REG_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALL   = 2'd1,
    RESOLVE = 2'd2
  } brCtrlState_t;

  localparam int BR_STALL_LD_EX  = 2;
  localparam int BR_STALL_LD_MEM = 1;

  // A source operand matches a pending load destination. x0 never matches
  // because writes to it are discarded and the regfile always reads zero.
  function automatic logic load_dep(input logic     reg_write,
                                    input logic     mem_read,
                                    input regName_t rd,
                                    input regName_t rs1,
                                    input regName_t rs2);
    return reg_write & mem_read & (rd != REG_ZERO) & ((rd == rs1) | (rd == rs2));
  endfunction

endpackage

// File: rtl/branch_hazard_ctrl_operand_hazard.sv
// ---------------------------------------------------------------------------
// branch_operand_hazard
// Purely combinational detection of branch operands that the comparator
// forwarding network cannot supply: a load result still in EX or MEM.
// ALU results in EX/MEM are forwarded to the comparator and are not hazards.
// Also usable by the main hazard unit.
//
// Ports:
//   rs1, rs2         in   branch source registers
//   rd_ex, rd_mem    in   destination registers in EX and MEM
//   reg_write_ex/mem in   register-write enables in EX and MEM
//   mem_read_ex/mem  in   producer in EX / MEM is a load
//   haz_ex           out  an operand depends on the load in EX
//   haz_mem          out  an operand depends on the load in MEM
// ---------------------------------------------------------------------------
module branch_operand_hazard
  import branch_hazard_ctrl_pkg::*;
(
  input  regName_t rs1,
  input  regName_t rs2,
  input  regName_t rd_ex,
  input  regName_t rd_mem,
  input  logic     reg_write_ex,
  input  logic     reg_write_mem,
  input  logic     mem_read_ex,
  input  logic     mem_read_mem,
  output logic     haz_ex,
  output logic     haz_mem
);

  assign haz_ex  = load_dep(reg_write_ex,  mem_read_ex,  rd_ex,  rs1, rs2);
  assign haz_mem = load_dep(reg_write_mem, mem_read_mem, rd_mem, rs1, rs2);

endmodule

// File: rtl/branch_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// branch_hazard_ctrl
// Sequencing controller for the ID-stage branch comparator. A branch whose
// operands are all forwardable resolves in the same cycle it is decoded. If
// an operand comes from a load still in EX or MEM, the front end is stalled
// until regfile write-through can supply it, then the branch resolves.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | no branch in flight; decode a new branch (resolve or stall)
//   STALL   | waiting on a load producer; cnt = stall cycles still to go
//   RESOLVE | operands ready; comparator result is used this cycle
//
// Parameters:
//   STALL_LD_EX   stall cycles for a load producer in EX  (default 2)
//   STALL_LD_MEM  stall cycles for a load producer in MEM (default 1)
//   CNT_WIDTH     stall counter width
//
// Ports:
//   clk                     in   system clock, rising edge
//   rstN                    in   synchronous active-low reset
//   branchID                in   ID instruction is a conditional branch
//   rs1ID, rs2ID            in   branch source registers
//   rdEX, rdMeM             in   destination registers in EX / MEM
//   regWriteEX, regWriteMeM in   register-write enables in EX / MEM
//   memReadEX, memReadMeM   in   producer in EX / MEM is a load
//   branchN                 in   comparator taken result (used on resolve)
//   flushIn                 in   external flush; aborts any sequence
//   stallPC, stallIFID      out  hold PC and IF/ID
//   bubbleIDEX              out  insert NOP into ID/EX
//   resolve                 out  comparator result valid this cycle
//   pcSrcBranch             out  select branch target at the PC mux
//   flushIFID               out  squash the wrong-path fetch
//   brCount, takenCount,    out  performance counters (32-bit, wrapping);
//   stallCycles                  live only with BRANCH_CTRL_PERF_EN defined,
//                                otherwise tied to 0 with no flops
//
// The outputs are a function of the current state and the current decode
// inputs: a hazard-free branch must resolve with zero added latency.
// ---------------------------------------------------------------------------
module branch_hazard_ctrl
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int STALL_LD_EX  = BR_STALL_LD_EX,
  parameter int STALL_LD_MEM = BR_STALL_LD_MEM,
  parameter int CNT_WIDTH    = 2
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        branchID,
  input  regName_t    rs1ID,
  input  regName_t    rs2ID,
  input  regName_t    rdEX,
  input  regName_t    rdMeM,
  input  logic        regWriteEX,
  input  logic        regWriteMeM,
  input  logic        memReadEX,
  input  logic        memReadMeM,
  input  logic        branchN,
  input  logic        flushIn,
  output logic        stallPC,
  output logic        stallIFID,
  output logic        bubbleIDEX,
  output logic        resolve,
  output logic        pcSrcBranch,
  output logic        flushIFID,
  output logic [31:0] brCount,
  output logic [31:0] takenCount,
  output logic [31:0] stallCycles
);

  // The detect cycle in IDLE is already the first stall cycle, so the
  // counter is loaded with the remaining count (N-1). A one-cycle stall
  // therefore skips STALL and goes straight to RESOLVE.
  localparam bit EX_DIRECT  = (STALL_LD_EX  <= 1);
  localparam bit MEM_DIRECT = (STALL_LD_MEM <= 1);
  localparam logic [CNT_WIDTH-1:0] EX_LOAD  =
    EX_DIRECT  ? '0 : CNT_WIDTH'(STALL_LD_EX - 1);
  localparam logic [CNT_WIDTH-1:0] MEM_LOAD =
    MEM_DIRECT ? '0 : CNT_WIDTH'(STALL_LD_MEM - 1);

  brCtrlState_t         state;
  logic [CNT_WIDTH-1:0] cnt;

  logic haz_ex;
  logic haz_mem;
  logic haz_any;

  logic stall_c;
  logic resolve_c;
  logic taken_c;

  branch_operand_hazard u_operand_hazard (
    .rs1           (rs1ID),
    .rs2           (rs2ID),
    .rd_ex         (rdEX),
    .rd_mem        (rdMeM),
    .reg_write_ex  (regWriteEX),
    .reg_write_mem (regWriteMeM),
    .mem_read_ex   (memReadEX),
    .mem_read_mem  (memReadMeM),
    .haz_ex        (haz_ex),
    .haz_mem       (haz_mem)
  );

  assign haz_any = haz_ex | haz_mem;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (flushIn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (branchID && haz_ex) begin
            // EX producer is younger and needs the longer wait
            cnt   <= EX_LOAD;
            state <= EX_DIRECT ? RESOLVE : STALL;
          end else if (branchID && haz_mem) begin
            cnt   <= MEM_LOAD;
            state <= MEM_DIRECT ? RESOLVE : STALL;
          end
        end
        STALL: begin
          cnt <= cnt - CNT_WIDTH'(1);
          if (cnt == CNT_WIDTH'(1)) begin
            state <= RESOLVE;
          end
        end
        RESOLVE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Reset and flush both force every output low in the same cycle.
  always_comb begin
    stall_c   = 1'b0;
    resolve_c = 1'b0;
    taken_c   = 1'b0;
    if (rstN && !flushIn) begin
      case (state)
        IDLE: begin
          if (branchID) begin
            if (haz_any) begin
              stall_c = 1'b1;
            end else begin
              resolve_c = 1'b1;
              taken_c   = branchN;
            end
          end
        end
        STALL: begin
          stall_c = 1'b1;
        end
        RESOLVE: begin
          resolve_c = 1'b1;
          taken_c   = branchN;
        end
        default: begin
          stall_c   = 1'b0;
          resolve_c = 1'b0;
          taken_c   = 1'b0;
        end
      endcase
    end
  end

  assign stallPC     = stall_c;
  assign stallIFID   = stall_c;
  assign bubbleIDEX  = stall_c;
  assign resolve     = resolve_c;
  assign pcSrcBranch = taken_c;
  assign flushIFID   = taken_c;

  // A zero count in STALL would wrap to all-ones and stall for 2^CNT_WIDTH
  // cycles; the IDLE load path guarantees it never happens.
  cnt_nonzero_in_stall : assert property (
    @(posedge clk) disable iff (!rstN) (state == STALL) |-> (cnt != '0)
  );

`ifdef BRANCH_CTRL_PERF_EN
  logic [31:0] br_count_q;
  logic [31:0] taken_count_q;
  logic [31:0] stall_cycles_q;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      br_count_q     <= '0;
      taken_count_q  <= '0;
      stall_cycles_q <= '0;
    end else begin
      if (resolve_c) begin
        br_count_q <= br_count_q + 32'd1;
      end
      if (resolve_c && branchN) begin
        taken_count_q <= taken_count_q + 32'd1;
      end
      if (stall_c) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
    end
  end

  assign brCount     = br_count_q;
  assign takenCount  = taken_count_q;
  assign stallCycles = stall_cycles_q;
`else
  assign brCount     = 32'd0;
  assign takenCount  = 32'd0;
  assign stallCycles = 32'd0;
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_hazard_ctrl
// Directed scenarios with literal expectations, followed by randomized
// decode/pipeline traffic. A stall-budget model (remaining stall cycles plus
// a pending-resolve flag) predicts every output on every cycle.
// ---------------------------------------------------------------------------
module tb_branch_hazard_ctrl;
  import branch_hazard_ctrl_pkg::*;

  localparam int N_EX  = 2;
  localparam int N_MEM = 1;

  logic        clk = 1'b0;
  logic        rstN;
  logic        branchID;
  regName_t    rs1ID, rs2ID, rdEX, rdMeM;
  logic        regWriteEX, regWriteMeM, memReadEX, memReadMeM;
  logic        branchN, flushIn;
  logic        stallPC, stallIFID, bubbleIDEX, resolve, pcSrcBranch, flushIFID;
  logic [31:0] brCount, takenCount, stallCycles;

  int checks = 0;
  int errors = 0;

  // model state
  int          m_left    = 0;
  bit          m_res_due = 1'b0;
  logic [31:0] m_br      = '0;
  logic [31:0] m_taken   = '0;
  logic [31:0] m_stall   = '0;

  always #5 clk = ~clk;

  branch_hazard_ctrl dut (
    .clk         (clk),
    .rstN        (rstN),
    .branchID    (branchID),
    .rs1ID       (rs1ID),
    .rs2ID       (rs2ID),
    .rdEX        (rdEX),
    .rdMeM       (rdMeM),
    .regWriteEX  (regWriteEX),
    .regWriteMeM (regWriteMeM),
    .memReadEX   (memReadEX),
    .memReadMeM  (memReadMeM),
    .branchN     (branchN),
    .flushIn     (flushIn),
    .stallPC     (stallPC),
    .stallIFID   (stallIFID),
    .bubbleIDEX  (bubbleIDEX),
    .resolve     (resolve),
    .pcSrcBranch (pcSrcBranch),
    .flushIFID   (flushIFID),
    .brCount     (brCount),
    .takenCount  (takenCount),
    .stallCycles (stallCycles)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_out(input string name, input bit st, input bit res,
                            input bit pc, input bit fl);
    chk({name, ".stallPC"},     32'(stallPC),     32'(st));
    chk({name, ".stallIFID"},   32'(stallIFID),   32'(st));
    chk({name, ".bubbleIDEX"},  32'(bubbleIDEX),  32'(st));
    chk({name, ".resolve"},     32'(resolve),     32'(res));
    chk({name, ".pcSrcBranch"}, 32'(pcSrcBranch), 32'(pc));
    chk({name, ".flushIFID"},   32'(flushIFID),   32'(fl));
  endtask

  function automatic bit dep(input bit wr, input bit ld, input int rd,
                             input int r1, input int r2);
    return wr && ld && rd != 0 && (rd == r1 || rd == r2);
  endfunction

  // Per-cycle reference: sampled mid-cycle while inputs are stable, then the
  // model advances to the state it will hold after the coming rising edge.
  always @(negedge clk) begin
    bit e_stall, e_res, e_taken;
    int n;
    e_stall = 1'b0;
    e_res   = 1'b0;
    e_taken = 1'b0;
    if (!rstN || flushIn) begin
      m_left    = 0;
      m_res_due = 1'b0;
    end else if (m_left > 0) begin
      e_stall = 1'b1;
      m_left--;
      if (m_left == 0) m_res_due = 1'b1;
    end else if (m_res_due) begin
      e_res     = 1'b1;
      e_taken   = branchN;
      m_res_due = 1'b0;
    end else if (branchID) begin
      if (dep(regWriteEX, memReadEX, int'(rdEX), int'(rs1ID), int'(rs2ID)))
        n = N_EX;
      else if (dep(regWriteMeM, memReadMeM, int'(rdMeM), int'(rs1ID), int'(rs2ID)))
        n = N_MEM;
      else
        n = 0;
      if (n == 0) begin
        e_res   = 1'b1;
        e_taken = branchN;
      end else begin
        e_stall = 1'b1;
        m_left  = n - 1;
        if (m_left == 0) m_res_due = 1'b1;
      end
    end
    expect_out("model", e_stall, e_res, e_taken, e_taken);
`ifdef BRANCH_CTRL_PERF_EN
    chk("brCount",     brCount,     m_br);
    chk("takenCount",  takenCount,  m_taken);
    chk("stallCycles", stallCycles, m_stall);
`else
    chk("brCount",     brCount,     32'd0);
    chk("takenCount",  takenCount,  32'd0);
    chk("stallCycles", stallCycles, 32'd0);
`endif
    if (!rstN) begin
      m_br    = '0;
      m_taken = '0;
      m_stall = '0;
    end else begin
      if (e_res)            m_br    = m_br + 32'd1;
      if (e_res && e_taken) m_taken = m_taken + 32'd1;
      if (e_stall)          m_stall = m_stall + 32'd1;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    branchID    = 1'b0;
    rs1ID       = '0;
    rs2ID       = '0;
    rdEX        = '0;
    rdMeM       = '0;
    regWriteEX  = 1'b0;
    regWriteMeM = 1'b0;
    memReadEX   = 1'b0;
    memReadMeM  = 1'b0;
    branchN     = 1'b0;
    flushIn     = 1'b0;
  endtask

  task automatic set_ld_ex(input int r);
    rdEX       = regName_t'(r);
    regWriteEX = 1'b1;
    memReadEX  = 1'b1;
  endtask

  task automatic set_ld_mem(input int r);
    rdMeM       = regName_t'(r);
    regWriteMeM = 1'b1;
    memReadMeM  = 1'b1;
  endtask

  initial begin
    int pool [4];
    pool = '{0, 5, 6, 7};

    rstN = 1'b0;
    clr();
    branchID = 1'b1;
    rs1ID    = 5'd5;
    branchN  = 1'b1;
    next_cycle(); #2 expect_out("reset_gate", 0, 0, 0, 0);
    next_cycle(); clr(); rstN = 1'b1;
    #2 expect_out("idle_nobranch", 0, 0, 0, 0);

    // ALU producer in EX is forwarded: immediate taken resolve
    next_cycle(); clr(); branchID = 1'b1; rs1ID = 5'd5; rs2ID = 5'd1;
    rdEX = 5'd5; regWriteEX = 1'b1; branchN = 1'b1;
    #2 expect_out("alu_taken", 0, 1, 1, 1);

    // load in EX: two stall cycles, resolve on the third, not taken
    next_cycle(); clr(); branchID = 1'b1; rs1ID = 5'd5; rs2ID = 5'd2; set_ld_ex(5);
    #2 expect_out("ldex_s1", 1, 0, 0, 0);
    next_cycle(); #2 expect_out("ldex_s2", 1, 0, 0, 0);
    next_cycle(); #2 expect_out("ldex_res", 0, 1, 0, 0);

    // load in MEM only: one stall cycle, taken resolve
    next_cycle(); clr(); branchID = 1'b1; rs1ID = 5'd1; rs2ID = 5'd6; set_ld_mem(6);
    branchN = 1'b1;
    #2 expect_out("ldmem_s1", 1, 0, 0, 0);
    next_cycle(); #2 expect_out("ldmem_res", 0, 1, 1, 1);

    // load targeting x0 is not a dependency
    next_cycle(); clr(); branchID = 1'b1; rs1ID = 5'd0; rs2ID = 5'd3; set_ld_ex(0);
    #2 expect_out("ld_x0", 0, 1, 0, 0);

    // EX and MEM both hazards: EX length wins
    next_cycle(); clr(); branchID = 1'b1; rs1ID = 5'd5; rs2ID = 5'd6;
    set_ld_ex(5); set_ld_mem(6); branchN = 1'b1;
    #2 expect_out("both_s1", 1, 0, 0, 0);
    next_cycle(); #2 expect_out("both_s2", 1, 0, 0, 0);
    next_cycle(); #2 expect_out("both_res", 0, 1, 1, 1);

    // flush on the first STALL cycle aborts without a resolve
    next_cycle(); #2 expect_out("flush_det", 1, 0, 0, 0);
    next_cycle(); flushIn = 1'b1; #2 expect_out("flush_cyc", 0, 0, 0, 0);
    next_cycle(); flushIn = 1'b0; branchID = 1'b0; #2 expect_out("flush_after", 0, 0, 0, 0);
    next_cycle(); clr(); branchID = 1'b1; rs1ID = 5'd9; branchN = 1'b1;
    #2 expect_out("flush_idle", 0, 1, 1, 1);

    // reset in the middle of a stall
    next_cycle(); clr(); branchID = 1'b1; rs1ID = 5'd5; set_ld_ex(5);
    #2 expect_out("rst_det", 1, 0, 0, 0);
    next_cycle(); rstN = 1'b0; #2 expect_out("rst_cyc", 0, 0, 0, 0);
    next_cycle(); rstN = 1'b1; clr(); #2 expect_out("rst_after", 0, 0, 0, 0);
    next_cycle(); branchID = 1'b1; rs1ID = 5'd9; #2 expect_out("rst_idle", 0, 1, 0, 0);

    // hazard present but no branch in ID
    next_cycle(); clr(); rs1ID = 5'd5; set_ld_ex(5); branchN = 1'b1;
    #2 expect_out("nobranch_haz", 0, 0, 0, 0);

`ifdef BRANCH_CTRL_PERF_EN
    next_cycle(); clr(); rstN = 1'b0;
    next_cycle(); rstN = 1'b1; branchID = 1'b1; rs1ID = 5'd9; branchN = 1'b1;
    next_cycle(); branchN = 1'b0;
    next_cycle(); rs1ID = 5'd5; set_ld_ex(5);
    next_cycle();
    next_cycle();
    next_cycle(); clr();
    #2;
    chk("perf_br",    brCount,     32'd3);
    chk("perf_taken", takenCount,  32'd1);
    chk("perf_stall", stallCycles, 32'd2);
`endif

    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      rstN        = ($urandom_range(0, 49) != 0);
      flushIn     = ($urandom_range(0, 19) == 0);
      branchID    = $urandom_range(0, 1) == 1;
      rs1ID       = regName_t'(pool[$urandom_range(0, 3)]);
      rs2ID       = regName_t'(pool[$urandom_range(0, 3)]);
      rdEX        = regName_t'(pool[$urandom_range(0, 3)]);
      rdMeM       = regName_t'(pool[$urandom_range(0, 3)]);
      regWriteEX  = $urandom_range(0, 3) != 0;
      regWriteMeM = $urandom_range(0, 3) != 0;
      memReadEX   = $urandom_range(0, 1) == 1;
      memReadMeM  = $urandom_range(0, 1) == 1;
      branchN     = $urandom_range(0, 1) == 1;
    end

    next_cycle();
    clr();
    #6;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
